// File: rtl/pmod_step_decoder_pkg.sv
// Shared definitions for the PmodSTEP coil-pattern decoder: coil patterns,
// decoder states, fault codes and phase-rotation helpers.
package pmod_step_defs;

    localparam logic [3:0] OFF = 4'b0000;
    localparam logic [3:0] P1  = 4'b0001;
    localparam logic [3:0] P2  = 4'b0010;
    localparam logic [3:0] P3  = 4'b0100;
    localparam logic [3:0] P4  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_ILLEGAL = 2'b01,
        FC_SKIP    = 2'b10
    } fault_code_e;

    function automatic logic is_onehot(input logic [3:0] p);
        case (p)
            P1, P2, P3, P4: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    // Forward (+1) phase order is a rotate-left of the one-hot pattern.
    function automatic logic [3:0] rot_fwd(input logic [3:0] p);
        return {p[2:0], p[3]};
    endfunction

    function automatic logic [3:0] rot_rev(input logic [3:0] p);
        return {p[0], p[3:1]};
    endfunction

endpackage

// File: rtl/pmod_step_decoder_sync.sv
// STAGES-deep 4-bit synchroniser for the observed coil pattern, async reset to 0.
module pmod_step_sync #(
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] sync_q [STAGES];
    logic [3:0] sync_d [STAGES];

    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pmod_step_decoder.sv
// Decodes a one-hot PmodSTEP coil drive pattern into step strobes, direction and
// a signed position. Soft-limit flags are built only with PMOD_STEP_DEC_LIMIT_EN.
module pmod_step_decoder
    import pmod_step_defs::*;
#(
    parameter int POS_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int POS_MIN     = -1000,
    parameter int POS_MAX     = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       coil_in,
    input  logic             pos_clr,
    input  logic             fault_clr,
    output logic             step_pulse,
    output logic             step_dir,
    output logic [POS_W-1:0] position,
    output logic             active,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic             at_min,
    output logic             at_max
);

    if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("pmod_step_decoder: SYNC_STAGES must be 1..3");
    end
    if (POS_MIN > POS_MAX) begin : g_bad_limits
        $error("pmod_step_decoder: POS_MIN must not exceed POS_MAX");
    end

    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    logic [3:0]       cur;
    state_e           state_q, state_d;
    logic [3:0]       last_q, last_d;
    logic [POS_W-1:0] position_q, position_d;
    logic             step_pulse_q, step_pulse_d;
    logic             step_dir_q, step_dir_d;
    fault_code_e      fault_code_q, fault_code_d;
    logic             active_q, active_d;
    logic             fault_q, fault_d;

    pmod_step_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (coil_in),
        .q  (cur)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        position_d   = position_q;
        step_pulse_d = 1'b0;
        step_dir_d   = step_dir_q;
        fault_code_d = fault_code_q;

        case (state_q)
            // last is always OFF here, so any non-zero pattern is a change.
            ST_IDLE: begin
                if (cur != OFF) begin
                    if (is_onehot(cur)) begin
                        state_d = ST_TRACK;
                        last_d  = cur;
                    end else begin
                        state_d      = ST_FAULT;
                        fault_code_d = FC_ILLEGAL;
                    end
                end
            end
            ST_TRACK: begin
                if (cur != last_q) begin
                    if (cur == rot_fwd(last_q)) begin
                        step_pulse_d = 1'b1;
                        step_dir_d   = 1'b1;
                        position_d   = position_q + POS_ONE;
                        last_d       = cur;
                    end else if (cur == rot_rev(last_q)) begin
                        step_pulse_d = 1'b1;
                        step_dir_d   = 1'b0;
                        position_d   = position_q - POS_ONE;
                        last_d       = cur;
                    end else if (cur == OFF) begin
                        state_d = ST_IDLE;
                        last_d  = OFF;
                    end else if (is_onehot(cur)) begin
                        state_d      = ST_FAULT;
                        fault_code_d = FC_SKIP;
                    end else begin
                        state_d      = ST_FAULT;
                        fault_code_d = FC_ILLEGAL;
                    end
                end
            end
            ST_FAULT: begin
                // A still-illegal pattern at release keeps us faulted.
                if (fault_clr) begin
                    last_d = cur;
                    if (cur == OFF) begin
                        state_d      = ST_IDLE;
                        fault_code_d = FC_NONE;
                    end else if (is_onehot(cur)) begin
                        state_d      = ST_TRACK;
                        fault_code_d = FC_NONE;
                    end else begin
                        fault_code_d = FC_ILLEGAL;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                last_d  = OFF;
            end
        endcase

        // Clear wins over a coincident step; the strobe still reports the step.
        if (pos_clr) begin
            position_d = '0;
        end

        active_d = (state_d == ST_TRACK);
        fault_d  = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_q       <= OFF;
            position_q   <= '0;
            step_pulse_q <= 1'b0;
            step_dir_q   <= 1'b0;
            fault_code_q <= FC_NONE;
            active_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            position_q   <= position_d;
            step_pulse_q <= step_pulse_d;
            step_dir_q   <= step_dir_d;
            fault_code_q <= fault_code_d;
            active_q     <= active_d;
            fault_q      <= fault_d;
        end
    end

    assign step_pulse = step_pulse_q;
    assign step_dir   = step_dir_q;
    assign position   = position_q;
    assign active     = active_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

`ifdef PMOD_STEP_DEC_LIMIT_EN
    localparam logic signed [POS_W-1:0] POS_MIN_W = POS_W'(POS_MIN);
    localparam logic signed [POS_W-1:0] POS_MAX_W = POS_W'(POS_MAX);

    logic at_min_q, at_min_d;
    logic at_max_q, at_max_d;

    // Compare the next position so the flags move with position itself.
    always_comb begin
        at_min_d = ($signed(position_d) <= POS_MIN_W);
        at_max_d = ($signed(position_d) >= POS_MAX_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            at_min_q <= 1'b0;
            at_max_q <= 1'b0;
        end else begin
            at_min_q <= at_min_d;
            at_max_q <= at_max_d;
        end
    end

    assign at_min = at_min_q;
    assign at_max = at_max_q;
`else
    assign at_min = 1'b0;
    assign at_max = 1'b0;
`endif

endmodule

// File: doc/pmod_step_decoder.md
Name: pmod_step_decoder

Overview:
Monitors the 4-wire one-hot coil drive pattern going to a PmodSTEP and decodes it back into step events, direction and a signed position count. It closes the loop on the claw gantry and detects illegal coil patterns. It sits beside each stepper driver instance and feeds the claw position and fault logic.

Parameters:
POS_W, 16, width of the signed position counter (two's complement)
SYNC_STAGES, 2, flip-flop stages on coil_in (legal 1..3)
POS_MIN, -1000, lower soft limit (used only with the optional feature)
POS_MAX, 1000, upper soft limit (used only with the optional feature)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
coil_in  in  4  coil pattern under observation
pos_clr  in  1  synchronous clear of position to 0
fault_clr  in  1  synchronous release from FAULT
step_pulse  out  1  one-cycle strobe per decoded step
step_dir  out  1  direction of the last step (1 = +1, 0 = -1); held between steps
position  out  POS_W  signed step count
active  out  1  coils energised (state TRACK)
fault  out  1  sticky fault flag
fault_code  out  2  00 none, 01 illegal pattern, 10 skipped phase
at_min  out  1  position <= POS_MIN (feature only, else 0)
at_max  out  1  position >= POS_MAX (feature only, else 0)

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: all outputs 0, synchroniser 0, last-pattern register 0, state IDLE.
- Sampling: coil_in passes through SYNC_STAGES flops to form cur. last holds the previous accepted pattern. All outputs are registered.
- Latency: a coil_in change shows on the outputs SYNC_STAGES+1 rising edges later.
- Phase order: rotate-left (0001→0010→0100→1000→0001) is +1. Rotate-right (0001→1000→0100→0010→0001) is -1.
- Steps are detected only on a change. If cur equals last, nothing happens, however long the pattern is held.
- State IDLE (last = 0000):
  - cur = 0000: stay.
  - cur one-hot: go to TRACK, last ← cur, no step (energise event only).
  - anything else: go to FAULT, code 01.
- State TRACK:
  - cur adjacent to last: step_pulse = 1 for one cycle, step_dir set, position ±1, last ← cur.
  - cur = 0000: go to IDLE, no step.
  - cur opposite to last (e.g. 0001→0100): go to FAULT, code 10.
  - cur neither zero nor one-hot: go to FAULT, code 01.
- State FAULT:
  - fault = 1, fault_code held, position frozen, no step pulses.
  - fault_clr: last ← cur. Next state is IDLE if cur = 0000, TRACK if cur is one-hot, otherwise stay in FAULT with code 01.
- active = 1 only in TRACK.
- Position:
  - Wraps modulo 2^POS_W (0x7FFF +1 → 0x8000).
  - pos_clr has priority: if pos_clr coincides with a step, position = 0, the step is discarded, but step_pulse and step_dir still report it.
  - pos_clr does not change state or fault.
- fault_clr and a new fault detected in the same cycle: the new fault wins.
- rst mid-sequence: immediate return to reset values; the first one-hot pattern after reset is an energise event, not a step.

Optional Feature:
- Macro: PMOD_STEP_DEC_LIMIT_EN.
- Defined: at_min and at_max are registered compares of the next position against POS_MIN/POS_MAX, updated in the same cycle as position. They are flags only; position is never saturated.
- Undefined: at_min and at_max are tied 0, the ports remain, and POS_MIN/POS_MAX are ignored.

Decomposition:
- Shared package/header pmod_step_defs: coil pattern constants P1=0001, P2=0010, P3=0100, P4=1000, OFF=0000; state encodings IDLE/TRACK/FAULT; fault code constants.
- One sub-module: pmod_step_sync, a SYNC_STAGES-deep 4-bit synchroniser with asynchronous reset to 0.

Test Plan:
- Reset then coil_in 0000→0001→0010→0100→1000→0001, each held 8 cycles → four step_pulses, step_dir=1, position=4, active=1, each pulse SYNC_STAGES+1 edges after its change.
- From position 4, sequence 0001→1000→0100 → two pulses, step_dir=0, position=2; then 0000 → active=0, position stays 2.
- Jump 0010→1000 → fault=1, fault_code=10, position frozen. Apply fault_clr with coil_in=1000 → TRACK, next 1000→0001 gives position +1.
- coil_in=0011 from IDLE → fault_code=01. fault_clr with 0011 still present → remains FAULT; with 0000 → IDLE, fault=0.
- Preload by stepping to 0x7FFF (POS_W=16, force via pos_clr plus a long run), one +1 step → position=0x8000. pos_clr coincident with a step → position=0, step_pulse=1.
- With PMOD_STEP_DEC_LIMIT_EN, POS_MAX=3: steps to 3 → at_max=1 on the same cycle position becomes 3; a -1 step → at_max=0. Without the macro, at_min and at_max stay 0 throughout.
